uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx byte transmitter among N_REQ byte producers using round-robin arbitration.
//  A winner may hold the grant for a burst of up to MAX_BURST consecutive bytes.
//  When TAG_EN=1, each burst is preceded by a header byte that identifies the requester.
//  Sits between the client logic and uart_tx: drives its i_valid/i_tx_data and watches its o_ready.
// PARAMETERS
//  N_REQ      4  number of requesters, legal range 2..4; requester id is 2 bits
//  MAX_BURST  4  maximum data bytes per grant, legal range 1..15
//  TAG_EN     1  1 = send header 8'hA0|id before each burst; 0 = no header
// PORTS
//  i_clk25MHz   in   1        system clock
//  i_reset      in   1        reset, asynchronous, active-high
//  i_req_valid  in   N_REQ    requester k has a byte; must stay high with data stable until accepted
//  i_req_data   in   8*N_REQ  byte of requester k on bits [8k+7:8k]
//  o_req_ack    out  N_REQ    one-cycle pulse: byte of requester k accepted (copied to holding register)
//  o_tx_data    out  8        byte to uart_tx i_tx_data
//  o_tx_valid   out  1        to uart_tx i_valid; single-cycle pulse, only while i_tx_ready=1
//  i_tx_ready   in   1        from uart_tx o_ready; high = transmitter idle
//  o_grant_id   out  2        id of the current or last grant holder
//  o_busy       out  1        high in every state except ARB
// BEHAVIOUR
//  Reset values
//   All outputs 0. State ARB, round-robin pointer 0, burst count 0.
//   Reset mid-frame aborts the sequence immediately; no ack is issued.
//   uart_tx receives the same reset and abandons its frame.
//  Registered outputs
//   All outputs are registered.
//   o_tx_valid is high for exactly one cycle per byte, in the cycle after the state enters ISSUE.
//  State ARB
//   Winner = first valid requester scanning from ptr, ptr+1, ..., wrapping modulo N_REQ.
//   On a win, in one cycle: latch i_req_data of the winner into hold, pulse o_req_ack[winner],
//   set o_grant_id, set ptr = winner+1 (wraps), set burst count = 1.
//   Next state is HDR if TAG_EN=1, otherwise ISSUE with the data byte.
//   No requester valid -> stay in ARB.
//  State HDR
//   Byte = 8'hA0 | {6'b0,id}. Issued through ISSUE; after it, the flow returns to ISSUE with the hold byte.
//  State ISSUE
//   Wait until i_tx_ready=1, then drive o_tx_valid=1 for one cycle with o_tx_data. Next state WAIT_LO.
//  State WAIT_LO
//   Wait for i_tx_ready=0 (acceptance). No timeout. Then WAIT_HI.
//  State WAIT_HI
//   Wait for i_tx_ready=1 (stop bit done).
//   If the byte just sent was a header, go to ISSUE with the hold byte.
//   Else, if i_req_valid[id]=1 and burst count < MAX_BURST:
//    latch the next byte, pulse o_req_ack[id], increment burst count, go to ISSUE (no new header).
//   Else go to ARB.
//  Fairness and byte flow
//   After a burst ends, the same requester may win again only if no other requester is valid.
//   Exactly one o_req_ack pulse occurs per data byte; the header byte is never acked.
//   i_req_valid dropping without an ack is legal and the byte is not sent.
//   Once acked, a byte is always sent unless reset occurs.
//   Simultaneous requests in ARB: resolved by the pointer only; index order never matters.
//   Burst count is 4 bits and saturates; MAX_BURST=1 makes every byte a separate grant.
// TESTING
//  Bench uses a real uart_tx instance plus a serial line monitor.
//  T1 Single byte
//   Req1 valid, data 8'h55, TAG_EN=1.
//   -> Line carries A1 then 55; one ack on req1; o_busy returns 0 after the stop bit of 55.
//  T2 Round-robin
//   All 4 requesters permanently valid, MAX_BURST=1, ptr=0.
//   -> Grant order 0,1,2,3,0,...; line carries A0 d0 A1 d1 A2 d2 A3 d3.
//  T3 Burst limit
//   Req2 streams 6 bytes 01..06, MAX_BURST=4, req0 also valid.
//   -> A2 01 02 03 04, then A0 x, then A2 05 06.
//  T4 No header
//   TAG_EN=0, req3 sends 8'hC3 and 8'h3C back to back.
//   -> Line carries only C3 3C.
//   -> o_tx_valid asserts only while i_tx_ready=1, and 1 cycle wide.
//  T5 Withdrawal
//   Req1 raises valid then drops it before arbitration, while req0 holds the grant.
//   -> No ack to req1 and no A1 on the line.
//  T6 Reset mid-operation
//   Assert i_reset during the second data bit.
//   -> All outputs 0 the same cycle; line idle high; the next request starts cleanly from ptr 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx byte transmitter among N_REQ producers,
// with per-grant bursts of up to MAX_BURST bytes and an optional header byte per burst.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter bit TAG_EN    = 1'b1
) (
  input  logic                 i_clk25MHz,
  input  logic                 i_reset,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [8*N_REQ-1:0]   i_req_data,
  output logic [N_REQ-1:0]     o_req_ack,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  input  logic                 i_tx_ready,
  output logic [1:0]           o_grant_id,
  output logic                 o_busy
);

  // Handshakes: a requester holds valid with stable data until it sees its
  // one-cycle ack; toward uart_tx, o_tx_valid pulses for one cycle only while
  // i_tx_ready=1, and ready falling then rising marks the byte as fully sent.
  typedef enum logic [2:0] {ARB, HDR, ISSUE, WAIT_LO, WAIT_HI} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] burst_cnt;
  logic [7:0] hold;
  logic       is_hdr;

  logic       win_found;
  logic [1:0] win_id;
  logic [2:0] cand;
  logic [1:0] next_ptr;
  logic [7:0] win_byte;
  logic [7:0] cur_byte;

  // Scan downward so the requester closest to ptr is the last one written.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand      = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = 3'(ptr) + 3'(i);
      if (cand >= 3'(N_REQ)) cand = cand - 3'(N_REQ);
      if (i_req_valid[cand[1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[1:0];
      end
    end
  end

  assign next_ptr = (win_id == 2'(N_REQ - 1)) ? 2'd0 : win_id + 2'd1;
  assign win_byte = i_req_data[{win_id, 3'b000} +: 8];
  assign cur_byte = i_req_data[{o_grant_id, 3'b000} +: 8];

  always_ff @(posedge i_clk25MHz or posedge i_reset) begin
    if (i_reset) begin
      state      <= ARB;
      ptr        <= 2'd0;
      burst_cnt  <= 4'd0;
      hold       <= 8'd0;
      is_hdr     <= 1'b0;
      o_req_ack  <= '0;
      o_tx_data  <= 8'd0;
      o_tx_valid <= 1'b0;
      o_grant_id <= 2'd0;
      o_busy     <= 1'b0;
    end else begin
      o_req_ack  <= '0;
      o_tx_valid <= 1'b0;
      case (state)
        ARB: begin
          if (win_found) begin
            hold       <= win_byte;
            o_req_ack  <= N_REQ'(1) << win_id;
            o_grant_id <= win_id;
            ptr        <= next_ptr;
            burst_cnt  <= 4'd1;
            o_busy     <= 1'b1;
            if (TAG_EN) begin
              is_hdr <= 1'b1;
              state  <= HDR;
            end else begin
              is_hdr <= 1'b0;
              state  <= ISSUE;
            end
          end
        end
        HDR: state <= ISSUE;
        ISSUE: begin
          if (i_tx_ready) begin
            o_tx_valid <= 1'b1;
            o_tx_data  <= is_hdr ? (8'hA0 | {6'b0, o_grant_id}) : hold;
            state      <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!i_tx_ready) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (i_tx_ready) begin
            if (is_hdr) begin
              // The held data byte goes out right after its header.
              is_hdr <= 1'b0;
              state  <= ISSUE;
            end else if (i_req_valid[o_grant_id] && burst_cnt < 4'(MAX_BURST)) begin
              hold      <= cur_byte;
              o_req_ack <= N_REQ'(1) << o_grant_id;
              burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
              state     <= ISSUE;
            end else begin
              o_busy <= 1'b0;
              state  <= ARB;
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
